// File: rtl/uart_rx_fifo.sv
// UART receiver with 2-flop input synchroniser, framing checks and a first-word fall-through receive FIFO.
// Optional even parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic                          ser_rx,
    input  logic                          enable,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overflow
`ifdef UART_RX_PARITY_EN
    ,
    output logic                          parity_err
`endif
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state;
    logic                 sync1, sync2;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 push_req, do_push, do_pop, full;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= ser_rx;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (!enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (!sync2) begin
                            cnt   <= HALF_LOAD;
                            state <= START;
                        end
                    end
                    START: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (sync2) begin
                            state <= IDLE;
                        end else begin
                            cnt     <= BIT_LOAD;
                            bit_idx <= LAST_BIT;
                            par_bad <= 1'b0;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            shreg <= {sync2, shreg[DATA_BITS-1:1]};
                            cnt   <= BIT_LOAD;
                            if (bit_idx == '0) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx - 1'b1;
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            cnt <= BIT_LOAD;
                            if (sync2 != ^shreg) begin
                                par_bad    <= 1'b1;
                                parity_err <= 1'b1;
                            end
                            state <= STOP;
                        end
                    end
`endif
                    STOP: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (sync2) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end
                    WAIT_HIGH: begin
                        if (sync2) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // The push is decided in the stop-sample cycle itself so the write lands on that edge.
    assign push_req = enable && (state == STOP) && (cnt == '0) && sync2 && !par_bad;
    assign full     = (fifo_count == FULL_CNT);
    assign do_pop   = rd_en && (fifo_count != '0);
    assign do_push  = push_req && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= push_req && full && !do_pop;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign rd_valid = (fifo_count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: scoreboard queue of expected characters plus pulse counters.
module tb_uart_rx_fifo;
    localparam int CLKS  = 16;
    localparam int DBITS = 8;
    localparam int DEPTH = 8;
    localparam int HALF  = CLKS / 2;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_K = DBITS + 2;
`else
    localparam int STOP_K = DBITS + 1;
`endif
    // Edges after the start-bit launch edge at which the push lands.
    localparam int PUSH_EDGE = 3 + HALF + STOP_K * CLKS;

    logic             clock = 1'b0;
    logic             resetb = 1'b1;
    logic             ser_rx = 1'b1;
    logic             enable = 1'b1;
    logic             rd_en;
    logic [DBITS-1:0] rd_data;
    logic             rd_valid;
    logic [3:0]       fifo_count;
    logic             busy, frame_err, overflow;
`ifdef UART_RX_PARITY_EN
    logic             parity_err;
    bit               par_flip = 1'b0;
    int               n_perr = 0, exp_perr = 0;
`endif

    logic mon_rd_en = 1'b0;
    logic dir_rd_en = 1'b0;
    assign rd_en = mon_rd_en | dir_rd_en;

    uart_rx_fifo #(.CLKS_PER_BIT(CLKS), .DATA_BITS(DBITS), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .resetb     (resetb),
        .ser_rx     (ser_rx),
        .enable     (enable),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_count (fifo_count),
        .busy       (busy),
        .frame_err  (frame_err),
        .overflow   (overflow)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0;
    int n_ferr = 0, n_ovf = 0, exp_ferr = 0, exp_ovf = 0;
    logic [7:0] exp_q[$];
    bit auto_read = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a character with a good frame enters the queue unless it is full.
    task automatic model_push(input logic [7:0] d);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else exp_ovf++;
    endtask

    always @(negedge clock) begin
        if (frame_err === 1'b1) n_ferr++;
        if (overflow === 1'b1) n_ovf++;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) n_perr++;
`endif
    end

    always @(negedge clock) begin
        if (mon_rd_en) begin
            mon_rd_en = 1'b0;
        end else if (auto_read && resetb && rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_char: got 0x%0h expected none at %0t", rd_data, $time);
            end else begin
                check("rd_data", {24'b0, rd_data}, {24'b0, exp_q.pop_front()});
            end
            mon_rd_en = 1'b1;
        end
    end

    task automatic send_frame(input logic [7:0] d, input bit stop_val, input int extra_low);
        @(posedge clock); #1 ser_rx = 1'b0;
        repeat (CLKS) @(posedge clock);
        for (int i = 0; i < DBITS; i++) begin
            #1 ser_rx = d[i];
            repeat (CLKS) @(posedge clock);
        end
`ifdef UART_RX_PARITY_EN
        #1 ser_rx = (^d) ^ par_flip;
        repeat (CLKS) @(posedge clock);
`endif
        #1 ser_rx = stop_val;
        repeat (CLKS) @(posedge clock);
        if (!stop_val) repeat (extra_low) @(posedge clock);
        #1 ser_rx = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || rd_valid === 1'b1) && k < 4000) begin
            @(posedge clock); #1;
            k++;
        end
        check({name, "_drain_timeout"}, (k >= 4000) ? 32'd1 : 32'd0, 32'd0);
        repeat (2) @(posedge clock); #1;
        check({name, "_count_after_drain"}, fifo_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit         stop_ok;

        #2 resetb = 1'b0;
        #1;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow", overflow, 0);
        repeat (3) @(posedge clock);
        #1 resetb = 1'b1;
        repeat (4) @(posedge clock);

        // Single character with exact push timing.
        model_push(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                repeat (PUSH_EDGE) @(posedge clock);
                #1 check("pre_push_valid", rd_valid, 0);
                @(posedge clock); #1;
                check("push_valid", rd_valid, 1);
                check("push_head", rd_data, 8'hA5);
                check("push_count", fifo_count, 1);
            end
        join
        auto_read = 1'b1;
        wait_drain("single");
        check("single_valid_after_read", rd_valid, 0);

        // Start-bit glitch.
        @(posedge clock); #1 ser_rx = 1'b0;
        repeat (4) @(posedge clock);
        #1 check("glitch_busy", busy, 1);
        ser_rx = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check("glitch_busy_clear", busy, 0);
        check("glitch_ferr", n_ferr, exp_ferr);
        check("glitch_count", fifo_count, 0);

        // Bad stop bit, long low line, then recovery.
        exp_ferr++;
        send_frame(8'h3C, 1'b0, 40);
        repeat (4) @(posedge clock); #1;
        check("stop0_ferr", n_ferr, exp_ferr);
        check("stop0_count", fifo_count, 0);
        model_push(8'h12);
        send_frame(8'h12, 1'b1, 0);
        wait_drain("recover");

        // Overflow without a read on the ninth push.
        auto_read = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            d = 8'(i);
            model_push(d);
            send_frame(d, 1'b1, 0);
        end
        repeat (3) @(posedge clock); #1;
        check("ovf_pulses", n_ovf, exp_ovf);
        check("ovf_count", fifo_count, DEPTH);
        auto_read = 1'b1;
        wait_drain("ovf");

        // Full FIFO with a same-cycle read on the ninth push.
        auto_read = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'(i);
            model_push(d);
            send_frame(d, 1'b1, 0);
        end
        fork
            send_frame(8'h08, 1'b1, 0);
            begin
                repeat (PUSH_EDGE) @(posedge clock);
                #1 check("simul_head", rd_data, exp_q.pop_front());
                dir_rd_en = 1'b1;
                @(posedge clock);
                #1 dir_rd_en = 1'b0;
            end
        join
        model_push(8'h08);
        repeat (3) @(posedge clock); #1;
        check("simul_ovf", n_ovf, exp_ovf);
        check("simul_count", fifo_count, DEPTH);
        auto_read = 1'b1;
        wait_drain("simul");

        // Disabling the receiver mid-frame drops it silently.
        fork
            send_frame(8'h5A, 1'b1, 0);
            begin
                repeat (60) @(posedge clock);
                #1 check("en_busy_before", busy, 1);
                enable = 1'b0;
                @(posedge clock);
                #1 check("en_busy_after", busy, 0);
            end
        join
        enable = 1'b1;
        repeat (20) @(posedge clock); #1;
        check("en_count", fifo_count, 0);
        check("en_ferr", n_ferr, exp_ferr);

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        exp_perr++;
        send_frame(8'h01, 1'b1, 0);
        par_flip = 1'b0;
        repeat (4) @(posedge clock); #1;
        check("par_err_pulses", n_perr, exp_perr);
        check("par_err_count", fifo_count, 0);
        model_push(8'h01);
        send_frame(8'h01, 1'b1, 0);
        wait_drain("par_ok");
        check("par_ok_pulses", n_perr, exp_perr);
`endif

        // Asynchronous reset during data bit 4 with one character buffered.
        auto_read = 1'b0;
        model_push(8'h33);
        send_frame(8'h33, 1'b1, 0);
        repeat (3) @(posedge clock); #1;
        check("prerst_count", fifo_count, 1);
        d = 8'h55;
        @(posedge clock); #1 ser_rx = 1'b0;
        repeat (CLKS) @(posedge clock);
        for (int i = 0; i < 4; i++) begin
            #1 ser_rx = d[i];
            repeat (CLKS) @(posedge clock);
        end
        #1 ser_rx = d[4];
        repeat (HALF) @(posedge clock);
        #1 check("prerst_busy", busy, 1);
        #2 resetb = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_rd_valid", rd_valid, 0);
        check("midrst_rd_data", rd_data, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_overflow", overflow, 0);
        ser_rx = 1'b1;
        repeat (3) @(posedge clock);
        #1 resetb = 1'b1;
        repeat (4) @(posedge clock);
        auto_read = 1'b1;
        model_push(8'h7E);
        send_frame(8'h7E, 1'b1, 0);
        wait_drain("post_reset");

        // Randomised traffic with occasional stop-bit errors.
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 5) != 0);
            if (stop_ok) model_push(d);
            else exp_ferr++;
            send_frame(d, stop_ok, int'($urandom_range(0, 20)));
            repeat ($urandom_range(2, 30)) @(posedge clock);
        end
        wait_drain("random");
        check("final_ferr", n_ferr, exp_ferr);
        check("final_ovf", n_ovf, exp_ovf);
        check("final_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
